// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the memory responder slice.
package mem_resp_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    COOLDOWN
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Line-request bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_resp_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, rd_count, wr_count
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, rd_count, wr_count
  );

endinterface

// File: rtl/mem_resp_array.sv
// Line storage: one synchronous write port, one combinational read port.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**IDX_W];

  // NOTE: storage has no reset; clearing it would defeat RAM inference and contents must survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line responder with IDLE/BUSY/RESPOND/COOLDOWN handshake.
// Optional read/write completion counters are built when MEM_RESPONDER_STATS_EN is defined.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 10
) (
  input  logic           clk,
  input  logic           proc_reset,
  mem_responder_if.slave bus
);

  state_e            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              accept;
  op_e               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] arr_rdata;
  logic              commit_wr;
  logic              respond_rd;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          accept   = 1'b1;
          cnt_nx   = 8'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        // Last BUSY cycle is the one where the counter steps to zero.
        if (cnt <= 8'd1) begin
          cnt_nx   = '0;
          state_nx = RESPOND;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      RESPOND:  state_nx = COOLDOWN;
      COOLDOWN: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // A read or write seen together is taken as a write.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= bus.mem_write ? OP_WRITE : OP_READ;
      idx_q   <= bus.mem_addr[IDX_W-1:0];
      wdata_q <= bus.mem_wdata;
    end
  end

  assign commit_wr  = (state == RESPOND) && (op_q == OP_WRITE);
  assign respond_rd = (state == RESPOND) && (op_q == OP_READ);

  mem_resp_array #(.IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (commit_wr),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)      rdata_q <= '0;
    else if (respond_rd) rdata_q <= arr_rdata;
  end

  // Read data is visible in the RESPOND cycle itself, then held until the next read.
  assign bus.mem_rdata = respond_rd ? arr_rdata : rdata_q;
  assign bus.mem_ready = (state == RESPOND);

`ifdef MEM_RESPONDER_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (respond_rd) rd_cnt_q <= sat_inc(rd_cnt_q);
      if (commit_wr)  wr_cnt_q <= sat_inc(wr_cnt_q);
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder (LATENCY 8 and LATENCY 1 instances).
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int LAT0 = 8;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  always #5 clk = ~clk;

  logic              sel = 1'b0;
  logic              req_read = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_wdata = '0;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  assign b0.mem_read  = req_read  & ~sel;
  assign b0.mem_write = req_write & ~sel;
  assign b0.mem_addr  = req_addr;
  assign b0.mem_wdata = req_wdata;
  assign b1.mem_read  = req_read  & sel;
  assign b1.mem_write = req_write & sel;
  assign b1.mem_addr  = req_addr;
  assign b1.mem_wdata = req_wdata;

  mem_responder #(.LATENCY(LAT0), .IDX_W(10)) dut0 (.clk(clk), .proc_reset(proc_reset), .bus(b0));
  mem_responder #(.LATENCY(LAT1), .IDX_W(4))  dut1 (.clk(clk), .proc_reset(proc_reset), .bus(b1));

  int compared   = 0;
  int mismatched = 0;

  // Reference model: per-instance line contents, last read line, completed op counts.
  logic [LINE_W-1:0] model_mem [int];
  logic [LINE_W-1:0] last_rd [2];
  int n_rd = 0;
  int n_wr = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy();
    return sel ? b1.mem_ready : b0.mem_ready;
  endfunction

  function automatic logic [LINE_W-1:0] rdat();
    return sel ? b1.mem_rdata : b0.mem_rdata;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef MEM_RESPONDER_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  // One handshake: raise request, wait for mem_ready, hold through the following cycle, drop.
  task automatic do_op(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata);
    int lat, k, key;
    logic [LINE_W-1:0] got, exp;
    lat = sel ? LAT1 : LAT0;
    key = sel ? (4096 + int'(addr[3:0])) : int'(addr[9:0]);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    k = 0; got = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (rdy()) begin
        k = c;
        got = rdat();
        break;
      end
    end
    check("ready_latency", LINE_W'(k), LINE_W'(lat));
    if (k != 0) begin
      if (wr) begin
        model_mem[key] = wdata;
        if (!sel) n_wr++;
      end else begin
        exp = model_mem.exists(key) ? model_mem[key] : got;
        check("rdata_in_ready", got, exp);
        last_rd[sel] = exp;
        if (!sel) n_rd++;
      end
      @(negedge clk);
      check("ready_one_cycle", LINE_W'(rdy()), '0);
      check("rdata_hold", rdat(), last_rd[sel]);
    end
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (rdy()) pulses++;
    end
    check(tag, LINE_W'(pulses), '0);
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    logic [9:0] pool [8];
    bit written [8];
    int p;

    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 10'(40 + 37 * i);
      written[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", LINE_W'(b0.mem_ready), '0);
    check("reset_rdata", b0.mem_rdata, '0);
    check("reset_rd_count", LINE_W'(b0.rd_count), '0);
    check("reset_wr_count", LINE_W'(b0.wr_count), '0);
    check("reset_ready_l1", LINE_W'(b1.mem_ready), '0);
    proc_reset = 1'b0;
    @(negedge clk);

    // Write then read back the same line; a write must not disturb mem_rdata
    do_op(1'b0, 1'b1, 28'h0000010, 128'hDEADBEEF_00000000_00000000_00000001);
    do_op(1'b1, 1'b0, 28'h0000010, '0);
    check("rdata_after_read", b0.mem_rdata, 128'hDEADBEEF_00000000_00000000_00000001);

    // Simultaneous read and write is taken as a write
    do_op(1'b1, 1'b1, 28'h0000005, 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF);
    do_op(1'b1, 1'b0, 28'h0000005, '0);

    // Request held through the cooldown cycle must not start another operation
    watch_quiet("no_second_op", 12);

    // Reset mid-BUSY discards a pending write
    do_op(1'b0, 1'b1, 28'h0000007, 128'h1111);
    @(negedge clk);
    req_write = 1'b1; req_addr = 28'h0000007; req_wdata = 128'h2222;
    repeat (3) @(negedge clk);
    check("busy_no_ready", LINE_W'(b0.mem_ready), '0);
    proc_reset = 1'b1;
    req_write = 1'b0;
    #1;
    check("async_reset_ready", LINE_W'(b0.mem_ready), '0);
    check("async_reset_rdata", b0.mem_rdata, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    n_rd = 0;
    n_wr = 0;
    check("async_reset_rd_count", LINE_W'(b0.rd_count), '0);
    @(negedge clk);
    proc_reset = 1'b0;
    watch_quiet("aborted_no_ready", 12);
    do_op(1'b1, 1'b0, 28'h0000007, '0);

    // Completion counters: 3 reads and 2 writes since reset
    do_op(1'b0, 1'b1, 28'h0000020, 128'hA0A0);
    do_op(1'b0, 1'b1, 28'h0000021, 128'hB1B1);
    do_op(1'b1, 1'b0, 28'h0000020, '0);
    do_op(1'b1, 1'b0, 28'h0000021, '0);
    @(negedge clk);
    check("rd_count_3", LINE_W'(b0.rd_count), LINE_W'(exp_cnt(3)));
    check("wr_count_2", LINE_W'(b0.wr_count), LINE_W'(exp_cnt(2)));

    // Randomized traffic with ignored upper address bits
    for (int t = 0; t < 24; t++) begin
      p = int'($urandom_range(0, 7));
      d = {$urandom, $urandom, $urandom, $urandom};
      if (!written[p] || ($urandom_range(0, 1) == 0)) begin
        written[p] = 1'b1;
        do_op(1'($urandom_range(0, 1)), 1'b1, {18'($urandom), pool[p]}, d);
      end else begin
        do_op(1'b1, 1'b0, {18'($urandom), pool[p]}, '0);
      end
    end
    @(negedge clk);
    check("rd_count_final", LINE_W'(b0.rd_count), LINE_W'(exp_cnt(n_rd)));
    check("wr_count_final", LINE_W'(b0.wr_count), LINE_W'(exp_cnt(n_wr)));

    // LATENCY=1 instance: ready the cycle after acceptance
    sel = 1'b1;
    do_op(1'b0, 1'b1, 28'h0000003, 128'h0123_4567_89AB_CDEF);
    do_op(1'b1, 1'b0, 28'h0000003, '0);
    check("l1_rdata", b1.mem_rdata, 128'h0123_4567_89AB_CDEF);
    watch_quiet("l1_no_second_op", 6);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
